// File: rtl/reward_packer_if.sv
//------------------------------------------------------------------------------
// reward_packer_if
// Word-stream transmit interface from the reward packer to the radio layer.
//
// Handshake: a word transfers on a rising clk edge when tx_valid && tx_ready.
// While tx_valid is high and tx_ready is low, tx_data and tx_last are held
// stable. Once a packet starts, tx_valid stays high until its last word
// (tx_last) has transferred.
//
// Signals:
//   tx_data   master->slave  packet word
//   tx_valid  master->slave  tx_data holds a valid word
//   tx_last   master->slave  current word is word 7 of the packet
//   tx_ready  slave->master  receiver accepts the word this cycle
//------------------------------------------------------------------------------
`timescale 1ns/1ps
interface reward_packer_if #(
    parameter int WORD_WIDTH = 16
);
    logic [WORD_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_last;
    logic                  tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  tx_last,
        output tx_ready
    );
endinterface

// File: rtl/reward_packer.sv
//------------------------------------------------------------------------------
// reward_packer
// Queues every transmit trigger a node sees (HB ripple, INV ripple, CH INV,
// MR/CHT timer expiry, data/SOS forward, own data/SOS), picks the highest
// priority pending one, snapshots the node info into an 8-word packet and
// streams it over the tx word interface.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   en                 launch enable (triggers still queue while low)
//   rx_valid/rx_type/rx_hopsFromCH/iAmDestination  filtered received packet
//   form_start         cluster formation strobe
//   have_data          own data strobe
//   role, low_E        CH flag, low-energy flag
//   myNodeID..nextHop  node info words
//   tx                 word stream (master side)
//   busy               high in LATCH/SEND/DONE
//   reward_done        one-cycle pulse after a packet completes
//   dbg_state          current FSM state
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module reward_packer #(
    parameter int                    WORD_WIDTH   = 16,
    parameter int                    MAX_INV_HOPS = 4,
    parameter int                    MR_TIMEOUT   = 15,
    parameter int                    CHT_TIMEOUT  = 15,
    parameter logic [WORD_WIDTH-1:0] SINK_ID      = '0,
    parameter logic [WORD_WIDTH-1:0] BCAST_ID     = '1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  rx_valid,
    input  logic [2:0]            rx_type,
    input  logic [WORD_WIDTH-1:0] rx_hopsFromCH,
    input  logic                  iAmDestination,
    input  logic                  form_start,
    input  logic                  have_data,
    input  logic                  role,
    input  logic                  low_E,
    input  logic [WORD_WIDTH-1:0] myNodeID,
    input  logic [WORD_WIDTH-1:0] myEnergy,
    input  logic [WORD_WIDTH-1:0] myQValue,
    input  logic [WORD_WIDTH-1:0] hopsFromSink,
    input  logic [WORD_WIDTH-1:0] chosenCH,
    input  logic [WORD_WIDTH-1:0] nextHop,
    reward_packer_if.master       tx,
    output logic                  busy,
    output logic                  reward_done,
    output logic [1:0]            dbg_state
);
    localparam int TMAX = (MR_TIMEOUT > CHT_TIMEOUT) ? MR_TIMEOUT : CHT_TIMEOUT;
    localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

    localparam logic [2:0] T_HB   = 3'b000;
    localparam logic [2:0] T_INV  = 3'b010;
    localparam logic [2:0] T_MR   = 3'b011;
    localparam logic [2:0] T_CHT  = 3'b100;
    localparam logic [2:0] T_DATA = 3'b101;
    localparam logic [2:0] T_SOS  = 3'b110;

    // Pending-bit indices; lower index = higher priority.
    localparam int P_HB    = 0;
    localparam int P_INV   = 1;
    localparam int P_CHINV = 2;
    localparam int P_MR    = 3;
    localparam int P_CHT   = 4;
    localparam int P_FWD   = 5;
    localparam int P_OWN   = 6;

    typedef enum logic [1:0] {S_IDLE, S_LATCH, S_SEND, S_DONE} state_t;

    state_t                state, state_nxt;
    logic [6:0]            pend, set_vec, sel;
    logic                  hb_lock;
    logic [WORD_WIDTH-1:0] inv_hops, inv_hops_inc;
    logic [TW-1:0]         timer;
    logic                  timer_expire;
    logic [2:0]            fwd_type;
    logic [WORD_WIDTH-1:0] pkt [8];
    logic [2:0]            widx;
    logic [2:0]            pkt_type;
    logic [WORD_WIDTH-1:0] pkt_dst, pkt_w7, route_dst;

    // A form_start in the same cycle reloads the timer and swallows the expiry.
    assign timer_expire = (timer == TW'(1)) && !form_start;
    assign inv_hops_inc = (rx_hopsFromCH == '1) ? '1 : rx_hopsFromCH + 1'b1;
    assign route_dst    = (hopsFromSink == WORD_WIDTH'(1)) ? SINK_ID : nextHop;
    // Isolate the lowest set bit = highest-priority pending trigger.
    assign sel          = pend & (~pend + 7'd1);

    always_comb begin
        set_vec          = '0;
        set_vec[P_HB]    = rx_valid && (rx_type == T_HB) && !hb_lock;
        set_vec[P_INV]   = rx_valid && (rx_type == T_INV) &&
                           (rx_hopsFromCH < WORD_WIDTH'(MAX_INV_HOPS));
        set_vec[P_CHINV] = form_start && role;
        set_vec[P_MR]    = timer_expire && !role;
        set_vec[P_CHT]   = timer_expire && role;
        set_vec[P_FWD]   = rx_valid && ((rx_type == T_DATA) || (rx_type == T_SOS)) &&
                           iAmDestination;
        set_vec[P_OWN]   = have_data;
    end

    // Packet header fields for the trigger being launched.
    always_comb begin
        pkt_type = T_HB;
        pkt_dst  = BCAST_ID;
        pkt_w7   = '0;
        if (sel[P_INV]) begin
            pkt_type = T_INV;
            pkt_w7   = inv_hops;
        end else if (sel[P_CHINV]) begin
            pkt_type = T_INV;
        end else if (sel[P_MR]) begin
            pkt_type = T_MR;
            pkt_dst  = chosenCH;
        end else if (sel[P_CHT]) begin
            pkt_type = T_CHT;
        end else if (sel[P_FWD]) begin
            pkt_type = fwd_type;
            pkt_dst  = route_dst;
        end else if (sel[P_OWN]) begin
            pkt_type = low_E ? T_SOS : T_DATA;
            pkt_dst  = route_dst;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic. IDLE looks at this cycle's triggers too so a trigger
    // reaches LATCH on the same edge that sets its pending bit.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (en && ((|pend) || (|set_vec))) state_nxt = S_LATCH;
            S_LATCH: state_nxt = S_SEND;
            S_SEND:  if (tx.tx_ready && (widx == 3'd7)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: pending bits, locks, timer, snapshot and word index.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= '0;
            hb_lock  <= 1'b0;
            inv_hops <= '0;
            timer    <= '0;
            fwd_type <= T_DATA;
            widx     <= '0;
            for (int i = 0; i < 8; i++) pkt[i] <= '0;
        end else begin
            // A new trigger in the LATCH cycle wins over the clear and re-pends.
            if (state == S_LATCH) pend <= (pend & ~sel) | set_vec;
            else                  pend <= pend | set_vec;

            if (set_vec[P_HB])                        hb_lock <= 1'b1;
            else if (rx_valid && (rx_type == T_DATA)) hb_lock <= 1'b0;

            if (set_vec[P_INV]) inv_hops <= inv_hops_inc;

            if (form_start)        timer <= role ? TW'(CHT_TIMEOUT) : TW'(MR_TIMEOUT);
            else if (timer != '0)  timer <= timer - TW'(1);

            if (set_vec[P_FWD]) fwd_type <= rx_type;

            if (state == S_LATCH) begin
                widx   <= '0;
                pkt[0] <= {{(WORD_WIDTH-3){1'b0}}, pkt_type};
                pkt[1] <= myNodeID;
                pkt[2] <= pkt_dst;
                pkt[3] <= myEnergy;
                pkt[4] <= myQValue;
                pkt[5] <= hopsFromSink;
                pkt[6] <= chosenCH;
                pkt[7] <= pkt_w7;
            end else if ((state == S_SEND) && tx.tx_ready) begin
                widx <= widx + 3'd1;
            end
        end
    end

    // Outputs
    always_comb begin
        tx.tx_valid = (state == S_SEND);
        tx.tx_data  = (state == S_SEND) ? pkt[widx] : '0;
        tx.tx_last  = (state == S_SEND) && (widx == 3'd7);
        busy        = (state != S_IDLE);
        reward_done = (state == S_DONE);
        dbg_state   = state;
    end
endmodule
